// File: rtl/riscv_axi_master_bridge_pkg.sv
// Shared types and constants for the core-to-AXI4-Lite master bridge.
// AXI response codes and FSM state encodings are kept here so that the slave side can reuse them.
package riscv_axi_master_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } state_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/riscv_axi_master_bridge_if.sv
// Core request port plus AXI4-Lite master channels, bundled for the bridge.
// Handshake rule on every channel: a transfer happens on a rising edge where VALID && READY are both high.
interface riscv_axi_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_ready;
    logic                  mem_done;
    logic                  mem_err;
    logic [DATA_W-1:0]     mem_rdata;

    logic [ADDR_W-1:0]     M_AXI_AWADDR;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_W-1:0]     M_AXI_WDATA;
    logic [DATA_W/8-1:0]   M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [ADDR_W-1:0]     M_AXI_ARADDR;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_W-1:0]     M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_done, mem_err, mem_rdata,
        output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
    );

    modport slave (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_done, mem_err, mem_rdata,
        input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
    );

endinterface

// File: rtl/riscv_axi_master_bridge.sv
// Single-outstanding core load/store port to AXI4-Lite master, one transaction at a time.
// A per-transaction cycle counter forces an error completion if the slave hangs.
module riscv_axi_master_bridge
    import riscv_axi_master_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic   clk,
    input  logic   rst,
    riscv_axi_master_bridge_if.master bus,
    output state_t o_state
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t                r_state, w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_aw_done, r_w_done;
    logic [CNT_W-1:0]      r_tmo_cnt;

    logic w_timeout, w_accept;
    logic w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
    logic w_aw_hs, w_w_hs, w_done, w_err, w_rd_cap;

    assign w_accept  = (r_state == ST_IDLE) && bus.mem_req;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state != ST_IDLE) && (r_tmo_cnt == CNT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // The timeout overrides every channel: all VALID/READY drop in the error cycle.
    always_comb begin
        w_next    = r_state;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_aw_hs   = 1'b0;
        w_w_hs    = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_rd_cap  = 1'b0;
        if (w_timeout) begin
            w_done = 1'b1;
            w_err  = 1'b1;
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req) w_next = bus.mem_we ? ST_WR_REQ : ST_RD_REQ;
                end
                ST_WR_REQ: begin
                    w_awvalid = !r_aw_done;
                    w_wvalid  = !r_w_done;
                    w_aw_hs   = w_awvalid && bus.M_AXI_AWREADY;
                    w_w_hs    = w_wvalid && bus.M_AXI_WREADY;
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    w_bready = 1'b1;
                    if (bus.M_AXI_BVALID) begin
                        w_done = 1'b1;
                        w_err  = resp_is_err(bus.M_AXI_BRESP);
                        w_next = ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    w_arvalid = 1'b1;
                    if (bus.M_AXI_ARREADY) w_next = ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    w_rready = 1'b1;
                    if (bus.M_AXI_RVALID) begin
                        w_done   = 1'b1;
                        w_err    = resp_is_err(bus.M_AXI_RRESP);
                        w_rd_cap = 1'b1;
                        w_next   = ST_IDLE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= bus.mem_addr;
                r_wdata   <= bus.mem_wdata;
                r_wstrb   <= bus.mem_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_rd_cap) r_rdata <= bus.M_AXI_RDATA;
        end
    end

    // Held at zero while idle, so it starts from zero on the first busy cycle; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                     r_tmo_cnt <= '0;
        else if (r_state == ST_IDLE)                                 r_tmo_cnt <= '0;
        else if ((TIMEOUT_CYCLES != 0) && (r_tmo_cnt != CNT_LIMIT))  r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end

    assign bus.mem_ready     = (r_state == ST_IDLE);
    assign bus.mem_done      = w_done;
    assign bus.mem_err       = w_err;
    assign bus.mem_rdata     = r_rdata;
    assign bus.M_AXI_AWADDR  = r_addr;
    assign bus.M_AXI_AWVALID = w_awvalid;
    assign bus.M_AXI_WDATA   = r_wdata;
    assign bus.M_AXI_WSTRB   = r_wstrb;
    assign bus.M_AXI_WVALID  = w_wvalid;
    assign bus.M_AXI_BREADY  = w_bready;
    assign bus.M_AXI_ARADDR  = r_addr;
    assign bus.M_AXI_ARVALID = w_arvalid;
    assign bus.M_AXI_RREADY  = w_rready;
    assign o_state           = r_state;

endmodule

// File: tb/tb_riscv_axi_master_bridge.sv
// Bench for riscv_axi_master_bridge: directed scenarios plus randomized traffic against a
// transaction-level reference model (word memory, expected latency, expected error/read data).
module tb_riscv_axi_master_bridge;
  import riscv_axi_master_bridge_pkg::*;

  localparam int TMO = 16;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  riscv_axi_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  riscv_axi_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .o_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {err, mem_rdata expected after completion}
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_rdata;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic clear_slave();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RDATA   = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctrl_zero"}, {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
              bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.mem_done, bus.mem_err}, 64'h0);
    check_val({tag, "_data_zero"}, {|bus.M_AXI_AWADDR, |bus.M_AXI_WDATA, |bus.M_AXI_WSTRB,
              |bus.M_AXI_ARADDR, |bus.mem_rdata}, 64'h0);
  endtask

  // Driver plus responding slave for one transaction. a_dly is the AW (write) or AR (read)
  // READY delay, rsp_dly the extra wait before B/R. hang = slave never accepts the request.
  // abort_c >= 0 pulses reset at that cycle of the transaction.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int a_dly, input int w_dly,
                         input int rsp_dly, input logic [1:0] resp, input bit hang,
                         input int abort_c);
    int c, done_c, aw_c, w_c, b_c, r_c, awv_cnt, wv_cnt, arv_cnt, exp_lat;
    bit aw_seen, w_seen, ar_seen, addr_bad, data_bad, order_bad, got_err, tmo_valids;
    bit aborted, exp_err;
    logic [31:0] rd_val, exp_rdata, cap_addr, cap_wdata, old_w;
    logic [3:0]  cap_wstrb;
    logic [32:0] entry;
    c = 0; done_c = -1; aw_c = 0; w_c = 0; b_c = -1; r_c = -1;
    awv_cnt = 0; wv_cnt = 0; arv_cnt = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; addr_bad = 0; data_bad = 0; order_bad = 0;
    got_err = 0; tmo_valids = 0; aborted = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0;

    // reference model: outcome of the transaction from the request alone
    exp_err = hang || (resp != AXI_RESP_OKAY);
    rd_val  = $urandom;
    if (we || hang)  exp_rdata = model_rdata;
    else if (exp_err) exp_rdata = rd_val;
    else              exp_rdata = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    if (hang)     exp_lat = TMO;
    else if (we)  exp_lat = ((a_dly > w_dly) ? a_dly : w_dly) + 2 + rsp_dly;
    else          exp_lat = a_dly + 2 + rsp_dly;
    exp_q.push_back({exp_err, exp_rdata});

    @(negedge clk);
    check_val("ready_before_req", bus.mem_ready, 1'b1);
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    @(posedge clk);
    #1;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'($urandom);
    bus.mem_addr  = $urandom;
    bus.mem_wdata = $urandom;
    bus.mem_wstrb = 4'($urandom);

    while (c < 40 && done_c < 0 && !aborted) begin
      @(negedge clk);
      if (bus.M_AXI_AWVALID) begin
        awv_cnt++;
        if (bus.M_AXI_AWADDR !== addr) addr_bad = 1;
      end
      if (bus.M_AXI_WVALID) begin
        wv_cnt++;
        if (bus.M_AXI_WDATA !== wdata || bus.M_AXI_WSTRB !== wstrb) data_bad = 1;
      end
      if (bus.M_AXI_ARVALID) begin
        arv_cnt++;
        if (bus.M_AXI_ARADDR !== addr) addr_bad = 1;
      end
      if (we && (bus.M_AXI_ARVALID || bus.M_AXI_RREADY)) order_bad = 1;
      if (!we && (bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_BREADY)) order_bad = 1;
      if (bus.M_AXI_BREADY && !(aw_seen && w_seen)) order_bad = 1;
      if (bus.M_AXI_RREADY && !ar_seen) order_bad = 1;

      if (c == abort_c) begin
        check_val("abort_in_wr_resp", bus.M_AXI_BREADY, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_txn");
        clear_slave();
        @(posedge clk);
        @(negedge clk);
        check_val("rst_no_done", bus.mem_done, 1'b0);
        rst = 1'b0;
        aborted = 1;
        model_rdata = 32'h0;
        void'(exp_q.pop_back());
      end else begin
        bus.M_AXI_AWREADY = !hang && we && (c >= a_dly);
        bus.M_AXI_WREADY  = !hang && we && (c >= w_dly);
        bus.M_AXI_ARREADY = !hang && !we && (c >= a_dly);
        if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
          aw_seen = 1; aw_c = c; cap_addr = bus.M_AXI_AWADDR;
        end
        if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
          w_seen = 1; w_c = c; cap_wdata = bus.M_AXI_WDATA; cap_wstrb = bus.M_AXI_WSTRB;
        end
        if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
          ar_seen = 1; r_c = c + 2 + rsp_dly; cap_addr = bus.M_AXI_ARADDR;
        end
        if (we && aw_seen && w_seen && b_c < 0) b_c = ((aw_c > w_c) ? aw_c : w_c) + 2 + rsp_dly;
        bus.M_AXI_BVALID = (b_c >= 0) && (c >= b_c);
        bus.M_AXI_BRESP  = resp;
        bus.M_AXI_RVALID = (r_c >= 0) && (c >= r_c);
        bus.M_AXI_RRESP  = resp;
        if (resp == AXI_RESP_OKAY)
          bus.M_AXI_RDATA = slave_mem.exists(cap_addr) ? slave_mem[cap_addr] : 32'h0;
        else
          bus.M_AXI_RDATA = rd_val;
        #1;
        if (bus.mem_done) begin
          done_c     = c;
          got_err    = bus.mem_err;
          tmo_valids = bus.M_AXI_AWVALID | bus.M_AXI_WVALID | bus.M_AXI_BREADY |
                       bus.M_AXI_ARVALID | bus.M_AXI_RREADY;
          if (we && bus.M_AXI_BVALID && bus.M_AXI_BREADY && resp == AXI_RESP_OKAY) begin
            old_w = slave_mem.exists(cap_addr) ? slave_mem[cap_addr] : 32'h0;
            slave_mem[cap_addr] = merge(old_w, cap_wdata, cap_wstrb);
          end
        end
        c++;
      end
    end

    if (!aborted) begin
      check_val(we ? "wr_latency" : "rd_latency", done_c, exp_lat);
      if (exp_q.size() == 0) begin
        check_val("scoreboard_empty", 1'b1, 1'b0);
        entry = '0;
      end else begin
        entry = exp_q.pop_front();
      end
      check_val("done_err", got_err, entry[32]);
      if (hang) begin
        check_val("tmo_valids_low", tmo_valids, 1'b0);
      end else if (we) begin
        check_val("aw_valid_cycles", awv_cnt, a_dly + 1);
        check_val("w_valid_cycles", wv_cnt, w_dly + 1);
        check_val("wr_addr_stable", addr_bad, 1'b0);
        check_val("wr_data_stable", data_bad, 1'b0);
        check_val("wr_chan_order", order_bad, 1'b0);
      end else begin
        check_val("ar_valid_cycles", arv_cnt, a_dly + 1);
        check_val("rd_addr_stable", addr_bad, 1'b0);
        check_val("rd_chan_order", order_bad, 1'b0);
      end
      @(posedge clk);
      #1;
      clear_slave();
      @(negedge clk);
      check_val("idle_after_done", {bus.mem_ready, bus.mem_done}, 2'b10);
      check_val("rdata_after_done", bus.mem_rdata, entry[31:0]);
      model_rdata = exp_rdata;
      if (we && !exp_err) begin
        old_w = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        ref_mem[addr] = merge(old_w, wdata, wstrb);
      end
    end
  endtask

  initial begin
    bit          held_bad;
    logic [1:0]  r_resp;
    rst = 1'b1;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'h0;
    bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0;
    clear_slave();
    model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check_val("reset_ready", bus.mem_ready, 1'b1);
    check_val("reset_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // basic write then read back, then check the read data is held
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, AXI_RESP_OKAY, 0, -1);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, AXI_RESP_OKAY, 0, -1);
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_rdata !== 32'hDEADBEEF) held_bad = 1;
    end
    check_val("rdata_hold_idle", held_bad, 1'b0);

    // independent AW / W handshake ordering
    run_txn(1'b1, 32'h14, 32'h12345678, 4'b0011, 3, 0, 0, AXI_RESP_OKAY, 0, -1);
    run_txn(1'b1, 32'h18, 32'hA5A5A5A5, 4'b1100, 0, 3, 1, AXI_RESP_OKAY, 0, -1);
    run_txn(1'b1, 32'h1C, 32'h0BADF00D, 4'hF, 2, 2, 2, AXI_RESP_OKAY, 0, -1);
    run_txn(1'b0, 32'h14, 32'h0, 4'h0, 2, 0, 3, AXI_RESP_OKAY, 0, -1);

    // error responses: failed write must not land, failed read still returns RDATA
    run_txn(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, AXI_RESP_SLVERR, 0, -1);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, AXI_RESP_DECERR, 0, -1);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1, 0, 0, AXI_RESP_OKAY, 0, -1);

    // hung slave on the read address channel
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 0, AXI_RESP_OKAY, 1, -1);
    // hung slave on a write
    run_txn(1'b1, 32'h24, 32'h11223344, 4'hF, 0, 0, 0, AXI_RESP_OKAY, 1, -1);

    // reset while waiting for B, then a normal write and read back
    run_txn(1'b1, 32'h30, 32'h11112222, 4'hF, 0, 0, 6, AXI_RESP_OKAY, 0, 3);
    run_txn(1'b1, 32'h30, 32'h33334444, 4'hF, 0, 0, 0, AXI_RESP_OKAY, 0, -1);
    run_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 0, AXI_RESP_OKAY, 0, -1);

    // randomized traffic over a small address window
    for (int n = 0; n < 40; n++) begin
      r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : AXI_RESP_OKAY;
      run_txn(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom,
              4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), r_resp, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
